// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - handshake/status bundle between a fifo_param instance and its user
interface fifo_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          Fclr;
    logic [DW-1:0] Din;
    logic          Wen;
    logic          Ren;
    logic [DW-1:0] Dout;
    logic          Dvalid;
    logic          Fempty;
    logic          Ffull;
    logic          Falmost_full;
    logic          Falmost_empty;
    logic [AW:0]   Count;
    logic          Ovf;
    logic          Udf;

    modport master (
        output Fclr, Din, Wen, Ren,
        input  Dout, Dvalid, Fempty, Ffull, Falmost_full, Falmost_empty, Count, Ovf, Udf
    );

    modport slave (
        input  Fclr, Din, Wen, Ren,
        output Dout, Dvalid, Fempty, Ffull, Falmost_full, Falmost_empty, Count, Ovf, Udf
    );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with count, level flags, sticky errors, flush
// Optional first-word-fall-through output selected by macro FIFO_FWFT_EN.
module fifo_param #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input logic         ck,
    input logic         rst,
    fifo_param_if.slave f
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_THR   = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_THR   = (AW+1)'(AE_LVL);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          empty_q;
    logic          full_q;
    logic          afull_q;
    logic          aempty_q;
    logic          ovf_q;
    logic          udf_q;
    logic          rd_ok;
    logic          wr_ok;

    // A write into a full FIFO is only legal when the same edge frees a slot.
    always_comb begin
        rd_ok     = f.Ren & ~empty_q;
        wr_ok     = f.Wen & (~full_q | rd_ok);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (f.Fclr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) rptr <= rptr + PTR_ONE;
            count    <= count_nxt;
            empty_q  <= (count_nxt == '0);
            full_q   <= (count_nxt == FULL_CNT);
            afull_q  <= (count_nxt >= AF_THR);
            aempty_q <= (count_nxt <= AE_THR);
            ovf_q    <= ovf_q | (f.Wen & ~wr_ok);
            udf_q    <= udf_q | (f.Ren & ~rd_ok);
        end
    end

    always_ff @(posedge ck) begin
        if (rst && !f.Fclr && wr_ok) begin
            mem[wptr] <= f.Din;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown as soon as the registered empty flag drops.
    assign f.Dout   = empty_q ? '0 : mem[rptr];
    assign f.Dvalid = ~empty_q;
`else
    logic [DW-1:0] dout_q;
    logic          dvalid_q;

    always_ff @(posedge ck) begin
        if (!rst) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else if (f.Fclr) begin
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= rd_ok;
            if (rd_ok) dout_q <= mem[rptr];
        end
    end

    assign f.Dout   = dout_q;
    assign f.Dvalid = dvalid_q;
`endif

    assign f.Fempty        = empty_q;
    assign f.Ffull         = full_q;
    assign f.Falmost_full  = afull_q;
    assign f.Falmost_empty = aempty_q;
    assign f.Count         = count;
    assign f.Ovf           = ovf_q;
    assign f.Udf           = udf_q;
endmodule
